// File: rtl/pc_stack_counter.sv
// rtl/pc_stack_counter.sv - program counter with load, increment and call/return stack
module pc_stack_counter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             lp,
  input  logic             cp,
  input  logic             ep,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] data_out,
  output logic             data_oe,
  output logic             wrap,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] stk_mem [0:(1<<AW)-1];
  logic [CW-1:0]    count;
  logic [CW-1:0]    top;
  logic [WIDTH-1:0] pc_inc;
  logic             push;
  logic             pop;

  assign pc_inc    = pc + 1'b1;
  assign top       = count - 1'b1;
  assign stk_full  = (count == CW'(DEPTH));
  assign stk_empty = (count == '0);
  assign data_out  = pc & {WIDTH{data_oe}};

  // Priority chain: clear > load > call > return > count > hold.
  assign push = clr_n && !lp && call && !stk_full;
  assign pop  = clr_n && !lp && !call && ret && !stk_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      count   <= '0;
      stk_err <= 1'b0;
      wrap    <= 1'b0;
      data_oe <= 1'b0;
    end else begin
      data_oe <= ep;
      wrap    <= 1'b0;
      if (!clr_n) begin
        pc      <= '0;
        count   <= '0;
        stk_err <= 1'b0;
      end else if (lp) begin
        pc <= data_in;
      end else if (call) begin
        if (push) begin
          pc    <= data_in;
          count <= count + 1'b1;
        end else begin
          stk_err <= 1'b1;
        end
      end else if (ret) begin
        if (pop) begin
          pc    <= stk_mem[top[AW-1:0]];
          count <= top;
        end else begin
          stk_err <= 1'b1;
        end
      end else if (cp) begin
        pc   <= pc_inc;
        wrap <= &pc;
      end
    end
  end

  // Entry contents need no reset; only the count decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      stk_mem[count[AW-1:0]] <= pc_inc;
    end
  end

endmodule
